// File: rtl/rv_pkg.sv
// Shared types and funct3 encodings for the RV32M divide unit.
package rv_pkg;

  typedef enum logic [1:0] {DIV_IDLE, DIV_CALC, DIV_DONE} div_state_t;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract
// the divisor, keep the difference only when it does not go negative.
module div_step
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic            dvdMsb,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] remNext,
  output logic            qBit
);

  // One extra bit so the borrow of the trial subtract is exact.
  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;

  always_comb begin
    shifted = {rem, dvdMsb};
    trial   = shifted - {1'b0, divisor};
    qBit    = ~trial[XLEN];
    remNext = qBit ? trial[XLEN-1:0] : shifted[XLEN-1:0];
  end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU beside the EX-stage ALU.
// Build option DIV_EARLY_OUT_EN: divide-by-zero and signed overflow finish right after accept.
//
// state    | meaning
// DIV_IDLE | no operation pending, result holds last value
// DIV_CALC | one restoring iteration per clock, busy stalls the pipeline
// DIV_DONE | result valid, done pulses for this single cycle
module div_unit
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            clr_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY_OUT = 1'b1;
`else
  localparam bit EARLY_OUT = 1'b0;
`endif

  div_state_t state, stateNext;

  logic [CW-1:0]   count;
  logic [XLEN-1:0] dq;
  logic [XLEN-1:0] remReg;
  logic [XLEN-1:0] divisor;
  logic [XLEN-1:0] aHold;
  logic            negQ, negR, isRem, specZero, specOvf;

  logic            inSigned, inRem, inZero, inOvf, inSpecial;
  logic            accept, lastIter;
  logic [XLEN-1:0] aAbs, bAbs;

  logic [XLEN-1:0] stepRem;
  logic            stepQ;
  logic [XLEN-1:0] qFin, qFix, rFix, finalRes;

  // RISC-V defined results: x/0 gives all-ones or the dividend, MIN/-1 gives MIN or 0.
  function automatic logic [XLEN-1:0] specialResult(input logic wantRem,
                                                    input logic byZero,
                                                    input logic [XLEN-1:0] dividend);
    if (byZero) return wantRem ? dividend : '1;
    return wantRem ? '0 : MIN_NEG;
  endfunction

  always_comb begin
    inSigned  = (funct3 == F3_DIV) || (funct3 == F3_REM);
    inRem     = (funct3 == F3_REM) || (funct3 == F3_REMU);
    inZero    = (b == '0);
    inOvf     = inSigned && (a == MIN_NEG) && (b == '1);
    inSpecial = inZero || inOvf;
    aAbs      = (inSigned && a[XLEN-1]) ? -a : a;
    bAbs      = (inSigned && b[XLEN-1]) ? -b : b;
    accept    = start && !flush && (state != DIV_CALC);
    lastIter  = (state == DIV_CALC) && (count == CW'(XLEN-1));
  end

  div_step #(.XLEN(XLEN)) uStep (
    .rem     (remReg),
    .dvdMsb  (dq[XLEN-1]),
    .divisor (divisor),
    .remNext (stepRem),
    .qBit    (stepQ)
  );

  always_comb begin
    qFin = {dq[XLEN-2:0], stepQ};
    qFix = negQ ? -qFin : qFin;
    rFix = negR ? -stepRem : stepRem;
    if (specZero || specOvf) finalRes = specialResult(isRem, specZero, aHold);
    else                     finalRes = isRem ? rFix : qFix;
  end

  always_ff @(posedge clk) begin
    if (!clr_n) state <= DIV_IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      DIV_IDLE, DIV_DONE: begin
        if (flush)      stateNext = DIV_IDLE;
        else if (start) stateNext = (EARLY_OUT && inSpecial) ? DIV_DONE : DIV_CALC;
        else            stateNext = DIV_IDLE;
      end
      DIV_CALC: begin
        if (flush)         stateNext = DIV_IDLE;
        else if (lastIter) stateNext = DIV_DONE;
      end
      default: stateNext = DIV_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == DIV_CALC);
    done = (state == DIV_DONE);
  end

  // The dividend shifts out of the top of dq while quotient bits enter at the bottom.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      count    <= '0;
      dq       <= '0;
      remReg   <= '0;
      divisor  <= '0;
      aHold    <= '0;
      negQ     <= 1'b0;
      negR     <= 1'b0;
      isRem    <= 1'b0;
      specZero <= 1'b0;
      specOvf  <= 1'b0;
      result   <= '0;
    end else if (accept) begin
      count    <= '0;
      dq       <= aAbs;
      remReg   <= '0;
      divisor  <= bAbs;
      aHold    <= a;
      negQ     <= inSigned && (a[XLEN-1] ^ b[XLEN-1]);
      negR     <= inSigned && a[XLEN-1];
      isRem    <= inRem;
      specZero <= inZero;
      specOvf  <= inOvf;
      if (EARLY_OUT && inSpecial) result <= specialResult(inRem, inZero, a);
    end else if ((state == DIV_CALC) && !flush) begin
      dq     <= {dq[XLEN-2:0], stepQ};
      remReg <= stepRem;
      count  <= count + CW'(1);
      if (lastIter) result <= finalRes;
    end
  end

endmodule
